// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one external combinational ALU between two requesters. Each
//   requester has a valid/ready request channel (a, b, op) and a valid/ready
//   response channel (result, flags {N,Z,C,V}). One operation runs at a
//   time: IDLE (accept) -> EXEC (ALU evaluates latched operands) -> RESP
//   (hold response until taken) -> IDLE.
//
// Ports
//   clk, rst                       clock (rising edge), sync active-high reset
//   req{0,1}_valid/_ready          request handshake
//   req{0,1}_a/_b/_op              request payload (op: 00 ADD 01 SUB 10 AND 11 OR)
//   rsp{0,1}_valid/_ready          response handshake
//   rsp{0,1}_result/_flags         captured ALU result / flags
//   alu_a/_b/_op                   to ALU, always from latched registers
//   alu_result/_flags              from ALU
//   busy                           high whenever not IDLE
//
// Build option
//   ALU_ARB_FIXED_PRIO_EN  defined: requester 0 always wins a tie.
//                          undefined: round-robin on ties.

module alu_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [1:0]   req0_op,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [1:0]   req1_op,

  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [N-1:0] rsp0_result,
  output logic [3:0]   rsp0_flags,

  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp1_result,
  output logic [3:0]   rsp1_flags,

  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,

  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           grant_q, grant_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [1:0]     op_q, op_d;

  logic           rsp0_valid_q, rsp0_valid_d;
  logic [N-1:0]   rsp0_result_q, rsp0_result_d;
  logic [3:0]     rsp0_flags_q, rsp0_flags_d;
  logic           rsp1_valid_q, rsp1_valid_d;
  logic [N-1:0]   rsp1_result_q, rsp1_result_d;
  logic [3:0]     rsp1_flags_q, rsp1_flags_d;

  logic           any_valid;
  logic           sel;
  logic           rsp_ready_g;

  // Requester selection; depends only on valids and last_grant so ready
  // never loops back through the payload.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      sel = 1'b0;
`else
      sel = ~last_grant_q;
`endif
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  assign any_valid   = req0_valid | req1_valid;
  assign req0_ready  = (state_q == IDLE) && any_valid && !sel;
  assign req1_ready  = (state_q == IDLE) && any_valid &&  sel;
  assign rsp_ready_g = grant_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_flags_d  = rsp0_flags_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_flags_d  = rsp1_flags_q;

    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = sel;
          a_d     = sel ? req1_a  : req0_a;
          b_d     = sel ? req1_b  : req0_b;
          op_d    = sel ? req1_op : req0_op;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (grant_q) begin
          rsp1_result_d = alu_result;
          rsp1_flags_d  = alu_flags;
          rsp1_valid_d  = 1'b1;
        end else begin
          rsp0_result_d = alu_result;
          rsp0_flags_d  = alu_flags;
          rsp0_valid_d  = 1'b1;
        end
        last_grant_d = grant_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready_g) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_flags_q  <= '0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_flags_q  <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_flags_q  <= rsp0_flags_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_flags_q  <= rsp1_flags_d;
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_flags  = rsp0_flags_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_flags  = rsp1_flags_q;
  assign busy        = (state_q != IDLE);

endmodule
